// File: rtl/gbe_pkt_pkg.sv
// Shared types and constants for the multi-channel 10GbE transmit packetizer.
// Also holds the header-word packing used by the packetizer.
package gbe_pkt_pkg;

    localparam int DATA_W      = 64;
    localparam int HDR_MAGIC_W = 8;
    localparam int HDR_CH_W    = 8;
    localparam int HDR_SEQ_W   = 48;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } pkt_state_t;

    function automatic logic [DATA_W-1:0] pack_header(
        input logic [HDR_MAGIC_W-1:0] magic,
        input logic [HDR_CH_W-1:0]    ch,
        input logic [HDR_SEQ_W-1:0]   seq
    );
        return {magic, ch, seq};
    endfunction

endpackage

// File: rtl/gbe_tx_packetizer_if.sv
// Transmit-side bus between the packetizer (master) and the 10GbE core (slave).
interface gbe_tx_packetizer_if;
    import gbe_pkt_pkg::*;

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_end_of_frame;
    logic [31:0]       tx_dest_ip;
    logic [15:0]       tx_dest_port;
    logic              tx_afull;
    logic              tx_overflow;

    modport master (
        output tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
        input  tx_afull, tx_overflow
    );

    modport slave (
        input  tx_valid, tx_data, tx_end_of_frame, tx_dest_ip, tx_dest_port,
        output tx_afull, tx_overflow
    );

endinterface

// File: rtl/gbe_pkt_fifo.sv
// First-word-fall-through FIFO, one per input channel.
// The head word is readable combinationally whenever the FIFO is not empty.
module gbe_pkt_fifo
    import gbe_pkt_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic [AW:0]       o_level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] r_mem [2**AW];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_empty;
    logic              w_wr;
    logic              w_rd;

    assign o_full  = (r_level == DEPTH);
    assign w_empty = (r_level == '0);
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !w_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gbe_tx_packetizer.sv
// Multi-channel UDP packetizer feeding the 10GbE core transmit interface.
// Buffers per-channel sample streams and sends fixed-length packets round-robin.
module gbe_tx_packetizer
    import gbe_pkt_pkg::*;
#(
    parameter int         N_CH          = 4,
    parameter int         PAYLOAD_WORDS = 128,
    parameter int         FIFO_AW       = 10,
    parameter logic [7:0] HDR_MAGIC     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_cnt_clr,
    input  logic [N_CH-1:0]        i_in_valid,
    input  logic [DATA_W*N_CH-1:0] i_in_data,
    input  logic [31:0]            i_dest_ip,
    input  logic [15:0]            i_dest_port_base,
    gbe_tx_packetizer_if.master    tx,
    output logic [N_CH-1:0]        o_in_overflow,
    output logic                   o_tx_ovf_seen,
    output logic [31:0]            o_pkt_count,
    output logic [31:0]            o_drop_count
);

    localparam int                CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int                BEAT_W    = $clog2(PAYLOAD_WORDS);
    localparam logic [FIFO_AW:0]  LVL_THR   = (FIFO_AW + 1)'(PAYLOAD_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAYLOAD_WORDS - 1);

    pkt_state_t        r_state;
    pkt_state_t        w_state_nxt;

    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_eligible;
    logic [N_CH-1:0]   w_drop;
    logic [N_CH-1:0]   w_pop;
    logic [FIFO_AW:0]  w_level [N_CH];
    logic [DATA_W-1:0] w_rdata [N_CH];

    logic [CH_W-1:0]      r_rr_ptr;
    logic [CH_W-1:0]      r_grant;
    logic [BEAT_W-1:0]    r_beat;
    logic [HDR_SEQ_W-1:0] r_seq [N_CH];

    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_eof;
    logic [31:0]       r_tx_dest_ip;
    logic [15:0]       r_tx_dest_port;

    logic [N_CH-1:0]   r_in_overflow;
    logic              r_tx_ovf_seen;
    logic [31:0]       r_pkt_count;
    logic [31:0]       r_drop_count;

    logic              w_found;
    logic [CH_W-1:0]   w_pick;
    int                w_idx;
    logic              w_grant_load;
    logic              w_pop_en;
    logic              w_last;
    logic              w_tx_valid_nxt;
    logic              w_tx_eof_nxt;
    logic [DATA_W-1:0] w_tx_data_nxt;
    logic [4:0]        w_drop_num;
    logic [32:0]       w_drop_sum;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        gbe_pkt_fifo #(
            .AW (FIFO_AW)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_wr_en (i_in_valid[c]),
            .i_wdata (i_in_data[DATA_W*c +: DATA_W]),
            .i_rd_en (w_pop[c]),
            .o_rdata (w_rdata[c]),
            .o_full  (w_full[c]),
            .o_level (w_level[c])
        );

        assign w_eligible[c] = (w_level[c] >= LVL_THR);
        assign w_drop[c]     = i_in_valid[c] & w_full[c];
    end

    assign w_pop = w_pop_en ? (N_CH'(1) << r_grant) : '0;

    // Round-robin search: first eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = CH_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (i_en && !tx.tx_afull && w_found) w_state_nxt = HDR;
            HDR:  if (!tx.tx_afull) w_state_nxt = DATA;
            DATA: if (!tx.tx_afull && r_beat == LAST_BEAT) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered tx outputs, plus FIFO pop and grant strobes.
    always_comb begin
        w_grant_load   = 1'b0;
        w_pop_en       = 1'b0;
        w_last         = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_tx_eof_nxt   = 1'b0;
        w_tx_data_nxt  = '0;
        unique case (r_state)
            IDLE: begin
                w_grant_load = i_en && !tx.tx_afull && w_found;
            end
            HDR: begin
                if (!tx.tx_afull) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = pack_header(HDR_MAGIC, HDR_CH_W'(r_grant), r_seq[r_grant]);
                end
            end
            DATA: begin
                if (!tx.tx_afull) begin
                    w_tx_valid_nxt = 1'b1;
                    w_pop_en       = 1'b1;
                    w_tx_data_nxt  = w_rdata[r_grant];
                    w_tx_eof_nxt   = (r_beat == LAST_BEAT);
                    w_last         = (r_beat == LAST_BEAT);
                end
            end
            default: begin
                w_grant_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid     <= 1'b0;
            r_tx_data      <= '0;
            r_tx_eof       <= 1'b0;
            r_tx_dest_ip   <= '0;
            r_tx_dest_port <= '0;
            r_grant        <= '0;
            r_beat         <= '0;
            r_rr_ptr       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_seq[c] <= '0;
            end
        end else begin
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_eof   <= w_tx_eof_nxt;
            if (w_grant_load) begin
                r_grant        <= w_pick;
                r_tx_dest_ip   <= i_dest_ip;
                r_tx_dest_port <= i_dest_port_base + 16'(w_pick);
            end
            if (r_state == HDR) begin
                r_beat <= '0;
            end else if (w_pop_en) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_last) begin
                r_seq[r_grant] <= r_seq[r_grant] + 1'b1;
                r_rr_ptr       <= (r_grant == CH_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_drop_num = w_drop_num + 5'(w_drop[c]);
        end
        w_drop_sum = {1'b0, r_drop_count} + 33'(w_drop_num);
    end

    // Status counters saturate; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk) begin
        if (rst || i_cnt_clr) begin
            r_pkt_count   <= '0;
            r_drop_count  <= '0;
            r_in_overflow <= '0;
            r_tx_ovf_seen <= 1'b0;
        end else begin
            if (w_last && r_pkt_count != '1) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            r_drop_count  <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
            r_in_overflow <= r_in_overflow | w_drop;
            if (tx.tx_overflow) begin
                r_tx_ovf_seen <= 1'b1;
            end
        end
    end

    assign tx.tx_valid        = r_tx_valid;
    assign tx.tx_data         = r_tx_data;
    assign tx.tx_end_of_frame = r_tx_eof;
    assign tx.tx_dest_ip      = r_tx_dest_ip;
    assign tx.tx_dest_port    = r_tx_dest_port;

    assign o_in_overflow = r_in_overflow;
    assign o_tx_ovf_seen = r_tx_ovf_seen;
    assign o_pkt_count   = r_pkt_count;
    assign o_drop_count  = r_drop_count;

endmodule

// File: doc/gbe_tx_packetizer.md
Name: gbe_tx_packetizer

Overview:
- Multi-channel packetizer that drives the 10GbE core transmit interface (tx_valid/tx_data/tx_end_of_frame/tx_dest_ip/tx_dest_port, backpressured by tx_afull).
- Buffers N_CH independent 64-bit sample streams in per-channel FIFOs.
- Forms fixed-length UDP payloads, each carrying one header word, and arbitrates round-robin between channels.
- Generalises the single-stream fabric hookup to parametrised channel count, packet length and buffer depth, and adds per-channel sequence numbering and drop accounting.

Parameters:
- N_CH, 4, number of input channels (1..16).
- PAYLOAD_WORDS, 128, data words per packet, excluding the header (2..1024).
- FIFO_AW, 10, per-channel FIFO address width; depth is 2**FIFO_AW and must be >= PAYLOAD_WORDS.
- HDR_MAGIC, 8'hA5, top byte of the header word.

Ports:
- clk  in  1  system clock, shared with the 10GbE core clk
- rst  in  1  synchronous active-high reset
- en  in  1  enable starting of new packets
- cnt_clr  in  1  clears status counters and sticky flags
- in_valid  in  N_CH  per-channel write strobe
- in_data  in  64*N_CH  channel c occupies bits [64c+63:64c]
- dest_ip  in  32  destination IP for all channels
- dest_port_base  in  16  channel c is sent to port dest_port_base+c
- tx_valid  out  1  to core
- tx_data  out  64  to core
- tx_end_of_frame  out  1  to core
- tx_dest_ip  out  32  to core
- tx_dest_port  out  16  to core
- tx_afull  in  1  from core; no new word is presented while it is high
- tx_overflow  in  1  from core
- in_overflow  out  N_CH  sticky, per channel; set when a word is dropped on a full FIFO
- tx_ovf_seen  out  1  sticky copy of tx_overflow
- pkt_count  out  32  packets completed
- drop_count  out  32  words dropped, summed over all channels

Behaviour:
- Reset: all outputs 0, FIFOs flushed, sequence counters 0, round-robin pointer 0, FSM in IDLE.
- rst mid-packet aborts immediately: tx_valid drops the next cycle and no end_of_frame is sent.
- FIFO write: in_valid[c] with FIFO c not full writes in_data[c].
  - If FIFO c is full, the word is discarded, in_overflow[c] is set, and drop_count increments.
  - Several channels dropping in the same cycle add popcount to drop_count.
- FIFOs are first-word-fall-through: data is valid when not empty, with zero read latency.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - A channel is eligible when its FIFO level >= PAYLOAD_WORDS.
  - When en=1, tx_afull=0 and at least one channel is eligible, grant the first eligible channel searching from rr_ptr upward, with wrap.
  - Latch grant g, tx_dest_ip=dest_ip and tx_dest_port=dest_port_base+g (16-bit wrap), then go to HDR.
- HDR:
  - If tx_afull=0: tx_valid=1, tx_data={HDR_MAGIC, 8-bit g, 48-bit seq[g]}; go to DATA with beat counter 0.
  - If tx_afull=1: hold with tx_valid=0.
- DATA:
  - Each cycle with tx_afull=0, pop FIFO g and drive tx_valid=1 with that word.
  - Cycles with tx_afull=1 drive tx_valid=0 with no pop.
  - Beat PAYLOAD_WORDS-1 also asserts tx_end_of_frame.
  - After the last beat: seq[g]+=1 (48-bit wrap), pkt_count+=1, rr_ptr=(g+1) mod N_CH, go to IDLE.
- IDLE lasts at least 1 cycle between packets.
- All tx_* outputs are registered, and tx_valid is low in IDLE.
- The FIFO level check guarantees DATA never underflows.
- en deasserted mid-packet: the current packet completes and no new packet starts.
- cnt_clr:
  - Zeroes pkt_count, drop_count, in_overflow and tx_ovf_seen.
  - Does not affect sequence numbers or the FSM.
  - If cnt_clr coincides with an increment, the clear wins.
- Counters saturate at 2**32-1.
- tx_overflow: tx_ovf_seen is set sticky; no other reaction.

Decomposition:
- Package gbe_pkt_pkg holds:
  - FSM state enum {IDLE, HDR, DATA};
  - header field widths (magic 8, channel 8, seq 48);
  - the header-word packing function;
  - the data width constant 64.
- Sub-module gbe_pkt_fifo: synchronous FWFT FIFO of width 64 and depth 2**FIFO_AW, with a level output of FIFO_AW+1 bits. It is instantiated N_CH times.
- Arbiter, FSM and counters live in the top level.

Test Plan:
- Single packet (N_CH=4, PAYLOAD_WORDS=4): write 4 words 0x10..0x13 on channel 2.
  - Required: 5 tx_valid beats; header 0xA5_02_000000000000; data 0x10..0x13; eof on 0x13; tx_dest_port=base+2; pkt_count=1.
- Round-robin: fill channels 0, 1 and 3 with 4 words each, then raise en.
  - Required: packets sent in order 0, 1, 3.
  - Refill channel 0 → it is served after 3; its header seq=1.
- Backpressure: hold tx_afull=1 for 3 cycles at DATA beat 1.
  - Required: tx_valid=0 for those cycles; no words lost or duplicated; eof only on the 4th data word.
- Overflow (FIFO_AW=2): write 6 words on channel 1 with en=0.
  - Required: in_overflow=4'b0010, drop_count=2; after cnt_clr both read 0.
- rst mid-DATA: assert rst at beat 2.
  - Required: tx_valid=0 the next cycle; no eof; FIFOs empty; next packet on channel 0 carries header seq=0.
- en drop: deassert en during HDR.
  - Required: the packet completes with eof; no further packets while en=0 although channel 1 is eligible.
